// File: rtl/chess_pkg.sv
// Shared chess constants: piece encodings, board size, pawn start ranks,
// controller FSM states and the optional pawn double-push helper.
package chess_pkg;

   localparam int unsigned BOARD_SQ = 64;

   localparam logic [3:0] BROOK   = 4'd0;
   localparam logic [3:0] BKNIGHT = 4'd1;
   localparam logic [3:0] BBISHOP = 4'd2;
   localparam logic [3:0] BQUEEN  = 4'd3;
   localparam logic [3:0] BKING   = 4'd4;
   localparam logic [3:0] BPAWN   = 4'd5;
   localparam logic [3:0] WROOK   = 4'd6;
   localparam logic [3:0] WKNIGHT = 4'd7;
   localparam logic [3:0] WBISHOP = 4'd8;
   localparam logic [3:0] WQUEEN  = 4'd9;
   localparam logic [3:0] WKING   = 4'd10;
   localparam logic [3:0] WPAWN   = 4'd11;

   localparam logic [5:0] WPAWN_START_LO = 6'd8;
   localparam logic [5:0] WPAWN_START_HI = 6'd15;
   localparam logic [5:0] BPAWN_START_LO = 6'd48;
   localparam logic [5:0] BPAWN_START_HI = 6'd55;

   typedef enum logic [2:0] {StIdle, StLoad, StSettle, StCapture, StSend} ctrl_state_e;

   // Adds the two-square pawn push from the start rank when both squares ahead are empty
   // and the mesh already reports the single push.
   function automatic logic [63:0] pawn_double(input logic [63:0] mask, input logic [5:0] sq,
                                               input logic [3:0] piece, input logic [63:0] occ);
      logic [63:0] m;
      m = mask;
      if (piece == WPAWN && sq >= WPAWN_START_LO && sq <= WPAWN_START_HI) begin
         if (!occ[sq + 6'd8] && !occ[sq + 6'd16] && m[sq + 6'd8]) m[sq + 6'd16] = 1'b1;
      end else if (piece == BPAWN && sq >= BPAWN_START_LO && sq <= BPAWN_START_HI) begin
         if (!occ[sq - 6'd8] && !occ[sq - 6'd16] && m[sq - 6'd8]) m[sq - 6'd16] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/mask_serializer.sv
// Streams a captured 64-bit move mask as OUT_W-wide beats, lowest bits first,
// holding data stable under backpressure.
module mask_serializer
   import chess_pkg::*;
#(
   parameter int unsigned OUT_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic [BOARD_SQ-1:0] mask_i,
   input  logic                rsp_ready_i,
   output logic                rsp_valid_o,
   output logic [OUT_W-1:0]    rsp_data_o,
   output logic                rsp_last_o,
   output logic                done_o
);

   localparam int unsigned NumBeats = BOARD_SQ / OUT_W;
   localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

   logic [BOARD_SQ-1:0] mask_q;
   logic [BOARD_SQ-1:0] shifted;
   logic [BeatW-1:0]    beat_q, beat_d;
   logic                valid_q, valid_d;
   logic                hs;

   assign hs          = valid_q & rsp_ready_i;
   assign rsp_valid_o = valid_q;
   assign rsp_last_o  = valid_q & (beat_q == BeatW'(NumBeats - 1));
   assign done_o      = hs & rsp_last_o;

   // Beat counter and valid flag advance only on a handshake.
   always_comb begin
      beat_d  = beat_q;
      valid_d = valid_q;
      if (load_i) begin
         beat_d  = '0;
         valid_d = 1'b1;
      end else if (hs) begin
         if (rsp_last_o) begin
            beat_d  = '0;
            valid_d = 1'b0;
         end else begin
            beat_d = beat_q + BeatW'(1);
         end
      end
   end

   // Slice mux selecting the current beat.
   always_comb begin
      shifted    = mask_q >> (32'(beat_q) * OUT_W);
      rsp_data_o = shifted[OUT_W-1:0];
   end

   // Mask, beat and valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q  <= '0;
         beat_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (load_i) mask_q <= mask_i;
         beat_q  <= beat_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/move_query_ctrl.sv
// Move-query sequencer: loads one query into the move-generation mesh, clears it,
// waits SETTLE_CYCLES, captures the move bits and streams the mask back.
// Optional feature macro: MOVE_QUERY_PAWN_DOUBLE_EN adds pawn double pushes at capture.
module move_query_ctrl
   import chess_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned OUT_W         = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [5:0]          req_square_i,
   input  logic [3:0]          req_piece_i,
   input  logic [63:0]         req_occ_i,
   input  logic [63:0]         req_white_i,
   output logic                mesh_init_o,
   output logic [5:0]          mesh_square_calc_o,
   output logic [3:0]          mesh_piece_type_o,
   output logic [63:0]         mesh_occupied_o,
   output logic [63:0]         mesh_white_o,
   input  logic [63:0]         mesh_movebits_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [OUT_W-1:0]    rsp_data_o,
   output logic                rsp_last_o,
   output logic                rsp_err_o,
   output logic                busy_o
);

   ctrl_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ready_q, err_q;
   logic [5:0]  sq_q;
   logic [3:0]  piece_q;
   logic [63:0] occ_q, white_q;
   logic [63:0] cap_mask;
   logic        cap_err;
   logic        accept, ser_done, ser_valid;

   assign accept = (state_q == StIdle) & req_valid_i & ready_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic and settle counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:    if (accept) state_d = StLoad;
         StLoad: begin
            state_d = StSettle;
            cnt_d   = 8'(SETTLE_CYCLES - 1);
         end
         StSettle: begin
            if (cnt_q == 8'd0) state_d = StCapture;
            else               cnt_d   = cnt_q - 8'd1;
         end
         StCapture: state_d = StSend;
         StSend:    if (ser_done) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      mesh_init_o = (state_q == StIdle) || (state_q == StLoad);
      busy_o      = (state_q != StIdle);
   end

   // Captured mask: self-square cleared, illegal piece zeroes the mask.
   always_comb begin
      cap_err          = (piece_q > WPAWN);
      cap_mask         = mesh_movebits_i;
      cap_mask[sq_q]   = 1'b0;
      if (cap_err) cap_mask = '0;
`ifdef MOVE_QUERY_PAWN_DOUBLE_EN
      cap_mask = pawn_double(cap_mask, sq_q, piece_q, occ_q);
`endif
   end

   // Request capture, ready flag, settle counter and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sq_q    <= '0;
         piece_q <= '0;
         occ_q   <= '0;
         white_q <= '0;
      end else begin
         // Ready is registered so it drops the cycle after acceptance.
         ready_q <= (state_d == StIdle);
         cnt_q   <= cnt_d;
         if (state_q == StCapture) err_q <= cap_err;
         if (accept) begin
            sq_q    <= req_square_i;
            piece_q <= req_piece_i;
            occ_q   <= req_occ_i;
            white_q <= req_white_i;
         end
      end
   end

   assign req_ready_o        = ready_q;
   assign mesh_square_calc_o = sq_q;
   assign mesh_piece_type_o  = piece_q;
   assign mesh_occupied_o    = occ_q;
   assign mesh_white_o       = white_q;
   assign rsp_valid_o        = ser_valid;
   assign rsp_err_o          = ser_valid & err_q;

   mask_serializer #(
      .OUT_W (OUT_W)
   ) u_ser (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (state_q == StCapture),
      .mask_i      (cap_mask),
      .rsp_ready_i (rsp_ready_i),
      .rsp_valid_o (ser_valid),
      .rsp_data_o  (rsp_data_o),
      .rsp_last_o  (rsp_last_o),
      .done_o      (ser_done)
   );

endmodule

// File: tb/tb_move_query_ctrl.sv
// Directed table-driven bench for move_query_ctrl (SETTLE_CYCLES=4, OUT_W=32).
module tb_move_query_ctrl;

   localparam int unsigned Settle = 4;

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [5:0]  req_square;
   logic [3:0]  req_piece;
   logic [63:0] req_occ, req_white;
   logic        mesh_init;
   logic [5:0]  mesh_sq;
   logic [3:0]  mesh_pc;
   logic [63:0] mesh_occ, mesh_wht, mesh_mb;
   logic        rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
   logic [31:0] rsp_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  sq;
      logic [3:0]  piece;
      logic [63:0] occ;
      logic [63:0] mb;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   move_query_ctrl #(
      .SETTLE_CYCLES (Settle),
      .OUT_W         (32)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_square_i       (req_square),
      .req_piece_i        (req_piece),
      .req_occ_i          (req_occ),
      .req_white_i        (req_white),
      .mesh_init_o        (mesh_init),
      .mesh_square_calc_o (mesh_sq),
      .mesh_piece_type_o  (mesh_pc),
      .mesh_occupied_o    (mesh_occ),
      .mesh_white_o       (mesh_wht),
      .mesh_movebits_i    (mesh_mb),
      .rsp_valid_o        (rsp_valid),
      .rsp_ready_i        (rsp_ready),
      .rsp_data_o         (rsp_data),
      .rsp_last_o         (rsp_last),
      .rsp_err_o          (rsp_err),
      .busy_o             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One complete query; stall holds rsp_ready low for that many cycles on beat 0.
   task automatic do_query(input vec_t v, input int stall);
      int n;
      n = 0;
      while (!req_ready && n < 10) begin
         step();
         n++;
      end
      chk("ready_wait", req_ready, 1);
      req_square = v.sq;
      req_piece  = v.piece;
      req_occ    = v.occ;
      req_white  = ~v.occ;
      mesh_mb    = v.mb;
      req_valid  = 1'b1;
      rsp_ready  = (stall == 0);
      step();                                   // cycle 1: LOAD
      req_valid = 1'b0;
      chk("ready_drop", req_ready, 0);
      chk("busy_load", busy, 1);
      chk("init_load", mesh_init, 1);
      chk("mesh_sq", mesh_sq, v.sq);
      chk("mesh_pc", mesh_pc, v.piece);
      chk("mesh_occ", mesh_occ, v.occ);
      chk("mesh_white", mesh_wht, ~v.occ);
      step();                                   // cycle 2: SETTLE
      chk("init_settle", mesh_init, 0);
      n = 2;
      while (!rsp_valid && n < 40) begin
         step();
         n++;
      end
      chk("latency", n, 3 + Settle);
      chk("beat0_data", rsp_data, v.lo);
      chk("beat0_last", rsp_last, 0);
      chk("beat0_err", rsp_err, v.err);
      for (int i = 0; i < stall; i++) begin
         step();
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", rsp_data, v.lo);
         chk("stall_last", rsp_last, 0);
      end
      rsp_ready = 1'b1;
      step();
      chk("beat1_valid", rsp_valid, 1);
      chk("beat1_data", rsp_data, v.hi);
      chk("beat1_last", rsp_last, 1);
      chk("beat1_err", rsp_err, v.err);
      step();
      rsp_ready = 1'b0;
      chk("done_valid", rsp_valid, 0);
      chk("done_ready", req_ready, 1);
      chk("done_busy", busy, 0);
      chk("done_init", mesh_init, 1);
   endtask

   initial begin
      logic seen;
      vecs[0] = '{6'd0, 4'd6, 64'h0, 64'h0101_0101_0101_01FE, 32'h0101_01FE, 32'h0101_0101, 1'b0};
      vecs[1] = '{6'd10, 4'd13, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 1'b1};
      vecs[2] = '{6'd35, 4'd9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0};
`ifdef MOVE_QUERY_PAWN_DOUBLE_EN
      vecs[3] = '{6'd12, 4'd11, 64'h0, 64'h0010_0000, 32'h1010_0000, 32'h0, 1'b0};
      vecs[5] = '{6'd52, 4'd5, 64'h0, 64'h0000_1000_0000_0000, 32'h0, 32'h0000_1010, 1'b0};
`else
      vecs[3] = '{6'd12, 4'd11, 64'h0, 64'h0010_0000, 32'h0010_0000, 32'h0, 1'b0};
      vecs[5] = '{6'd52, 4'd5, 64'h0, 64'h0000_1000_0000_0000, 32'h0, 32'h0000_1000, 1'b0};
`endif
      vecs[4] = '{6'd12, 4'd11, 64'h1000_0000, 64'h0010_0000, 32'h0010_0000, 32'h0, 1'b0};
      vecs[6] = '{6'd20, 4'd12, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h0, 32'h0, 1'b1};
      vecs[7] = '{6'd63, 4'd10, 64'h0, 64'h8000_0000_0000_0001, 32'h0000_0001, 32'h0, 1'b0};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_square = '0;
      req_piece  = '0;
      req_occ    = '0;
      req_white  = '0;
      mesh_mb    = '0;
      rsp_ready  = 1'b0;
      step();
      chk("rst_ready", req_ready, 0);
      chk("rst_init", mesh_init, 1);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_last", rsp_last, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mesh", {mesh_sq, mesh_pc, mesh_occ, mesh_wht} == '0, 1);
      rst_n = 1'b1;
      step();
      chk("ready_rise", req_ready, 1);

      for (int i = 0; i < 8; i++) do_query(vecs[i], 0);

      // Backpressure on beat 0.
      do_query(vecs[0], 5);

      // Reset in the middle of SETTLE.
      req_square = 6'd7;
      req_piece  = 4'd3;
      req_occ    = 64'hFF;
      mesh_mb    = 64'hFFFF;
      req_valid  = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_init", mesh_init, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rsp_valid, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_sq", mesh_sq, 0);
      step();
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         seen = seen | rsp_valid;
      end
      chk("midrst_no_rsp", seen, 0);
      do_query(vecs[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
